// File: rtl/fp_csr_flags.sv
// FP control/status stage: sticky exception-flag accumulation, frm register,
// dynamic rounding-mode resolution and a CSR port that drains in-flight flags first.
module fp_csr_flags #(
  parameter int PIPE_DEPTH = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fp_valid_i,
  output logic        fp_stall_o,
  input  logic        invalid_i,
  input  logic        div_zero_i,
  input  logic        overflow_i,
  input  logic        underflow_i,
  input  logic        inexact_i,
  input  logic [2:0]  instr_rm_i,
  output logic [2:0]  eff_rm_o,
  output logic        rm_illegal_o,
  input  logic        csr_req_valid_i,
  output logic        csr_req_ready_o,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_rsp_valid_o,
  input  logic        csr_rsp_ready_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_err_o,
  output logic [4:0]  fflags_o,
  output logic [2:0]  frm_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                r_state;
  logic [PIPE_DEPTH-1:0] r_pipe;
  logic [4:0]            r_fflags;
  logic [2:0]            r_frm;
  logic [1:0]            r_op;
  logic [11:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic                  r_rsp_valid;

  logic [PIPE_DEPTH-1:0] w_pipe_next;
  logic                  w_flag_vld;
  logic [4:0]            w_flags_in;
  logic [4:0]            w_fflags_acc;
  logic [31:0]           w_old;
  logic [31:0]           w_new;
  logic                  w_addr_ok;
  logic                  w_write;

  if (PIPE_DEPTH == 1) begin : g_pipe1
    assign w_pipe_next = fp_valid_i;
  end else begin : g_pipen
    assign w_pipe_next = {r_pipe[PIPE_DEPTH-2:0], fp_valid_i};
  end

  assign w_flag_vld   = r_pipe[PIPE_DEPTH-1];
  assign w_flags_in   = {invalid_i, div_zero_i, overflow_i, underflow_i, inexact_i};
  assign w_fflags_acc = r_fflags | (w_flag_vld ? w_flags_in : 5'b0);

  // Old value and read-modify-write result for the latched request.
  always_comb begin
    w_old     = 32'b0;
    w_addr_ok = 1'b1;
    case (r_addr)
      12'h001: w_old = {27'b0, r_fflags};
      12'h002: w_old = {29'b0, r_frm};
      12'h003: w_old = {24'b0, r_frm, r_fflags};
      default: w_addr_ok = 1'b0;
    endcase
    case (r_op)
      2'b01:   w_new = r_wdata;
      2'b10:   w_new = w_old | r_wdata;
      2'b11:   w_new = w_old & ~r_wdata;
      default: w_new = w_old;
    endcase
  end

  assign w_write = w_addr_ok && (r_op != 2'b00);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_pipe      <= '0;
      r_fflags    <= 5'b0;
      r_frm       <= 3'b0;
      r_op        <= 2'b0;
      r_addr      <= 12'b0;
      r_wdata     <= 32'b0;
      r_rdata     <= 32'b0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_pipe   <= w_pipe_next;
      r_fflags <= w_fflags_acc;
      case (r_state)
        S_IDLE: begin
          if (csr_req_valid_i) begin
            r_op    <= csr_op_i;
            r_addr  <= csr_addr_i;
            r_wdata <= csr_wdata_i;
            r_state <= ((|r_pipe) || fp_valid_i) ? S_DRAIN : S_ACCESS;
          end
        end
        S_DRAIN: begin
          if (w_pipe_next == '0) r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          r_rdata     <= w_addr_ok ? w_old : 32'b0;
          r_err       <= ~w_addr_ok;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
          // A CSR write of the flag field takes precedence over accumulation.
          if (w_write && (r_addr == 12'h001 || r_addr == 12'h003)) r_fflags <= w_new[4:0];
          if (w_write && r_addr == 12'h002) r_frm <= w_new[2:0];
          if (w_write && r_addr == 12'h003) r_frm <= w_new[7:5];
        end
        S_RESP: begin
          if (csr_rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign eff_rm_o        = (instr_rm_i == 3'b111) ? r_frm : instr_rm_i;
  assign rm_illegal_o    = (eff_rm_o >= 3'd5);
  assign fp_stall_o      = (r_state != S_IDLE);
  assign csr_req_ready_o = (r_state == S_IDLE) && !rst_i;
  assign csr_rsp_valid_o = r_rsp_valid;
  assign csr_rdata_o     = r_rdata;
  assign csr_err_o       = r_err;
  assign fflags_o        = r_fflags;
  assign frm_o           = r_frm;

endmodule

// File: tb/tb_fp_csr_flags.sv
// Directed bench for fp_csr_flags: flag accumulation, CSR RMW, drain, rounding, errors, reset.
module tb_fp_csr_flags;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        fp_valid_i = 1'b0;
  logic        fp_stall_o;
  logic        invalid_i = 1'b0, div_zero_i = 1'b0, overflow_i = 1'b0;
  logic        underflow_i = 1'b0, inexact_i = 1'b0;
  logic [2:0]  instr_rm_i = 3'd0;
  logic [2:0]  eff_rm_o;
  logic        rm_illegal_o;
  logic        csr_req_valid_i = 1'b0;
  logic        csr_req_ready_o;
  logic [1:0]  csr_op_i = 2'd0;
  logic [11:0] csr_addr_i = 12'd0;
  logic [31:0] csr_wdata_i = 32'd0;
  logic        csr_rsp_valid_o;
  logic        csr_rsp_ready_i = 1'b0;
  logic [31:0] csr_rdata_o;
  logic        csr_err_o;
  logic [4:0]  fflags_o;
  logic [2:0]  frm_o;

  int n_checks = 0;
  int n_pass   = 0;

  fp_csr_flags #(.PIPE_DEPTH(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .fp_valid_i(fp_valid_i), .fp_stall_o(fp_stall_o),
    .invalid_i(invalid_i), .div_zero_i(div_zero_i), .overflow_i(overflow_i),
    .underflow_i(underflow_i), .inexact_i(inexact_i), .instr_rm_i(instr_rm_i),
    .eff_rm_o(eff_rm_o), .rm_illegal_o(rm_illegal_o),
    .csr_req_valid_i(csr_req_valid_i), .csr_req_ready_o(csr_req_ready_o),
    .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .csr_rsp_valid_o(csr_rsp_valid_o), .csr_rsp_ready_i(csr_rsp_ready_i),
    .csr_rdata_o(csr_rdata_o), .csr_err_o(csr_err_o),
    .fflags_o(fflags_o), .frm_o(frm_o)
  );

  always #5 clk_i = ~clk_i;

  // Issue must never present an op while the stage is stalled.
  always @(posedge clk_i) begin
    if (!rst_i && fp_stall_o)
      assert (!fp_valid_i) else $error("protocol: fp_valid_i while stalled");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_flags(input logic [4:0] f);
    {invalid_i, div_zero_i, overflow_i, underflow_i, inexact_i} = f;
  endtask

  // Called just after a posedge with the stage idle and the flag pipe empty.
  task automatic csr_txn(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int hold);
    csr_req_valid_i = 1'b1;
    csr_op_i        = op;
    csr_addr_i      = addr;
    csr_wdata_i     = wd;
    @(negedge clk_i);
    check("req_ready", {31'b0, csr_req_ready_o}, 32'd1);
    tick();
    csr_req_valid_i = 1'b0;
    @(negedge clk_i);
    check("rsp_not_early", {31'b0, csr_rsp_valid_o}, 32'd0);
    tick();
    @(negedge clk_i);
    check("rsp_valid", {31'b0, csr_rsp_valid_o}, 32'd1);
    check("rdata", csr_rdata_o, exp_rd);
    check("err", {31'b0, csr_err_o}, {31'b0, exp_err});
    for (int i = 0; i < hold; i++) begin
      tick();
      @(negedge clk_i);
      check("hold_valid", {31'b0, csr_rsp_valid_o}, 32'd1);
      check("hold_rdata", csr_rdata_o, exp_rd);
    end
    csr_rsp_ready_i = 1'b1;
    tick();
    csr_rsp_ready_i = 1'b0;
    $display("csr op=%0d addr=0x%03h wdata=0x%0h -> rdata=0x%0h err=%0d fflags=0x%0h frm=%0d",
             op, addr, wd, csr_rdata_o, csr_err_o, fflags_o, frm_o);
  endtask

  task automatic rm_case(input logic [2:0] rm, input logic [2:0] exp_rm, input logic exp_ill);
    instr_rm_i = rm;
    #1;
    check("eff_rm", {29'b0, eff_rm_o}, {29'b0, exp_rm});
    check("rm_illegal", {31'b0, rm_illegal_o}, {31'b0, exp_ill});
    $display("rm instr=%0d frm=%0d -> eff=%0d illegal=%0d", rm, frm_o, eff_rm_o, rm_illegal_o);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", {31'b0, csr_req_ready_o}, 32'd0);
    check("rst_fflags", {27'b0, fflags_o}, 32'd0);
    check("rst_frm", {29'b0, frm_o}, 32'd0);
    check("rst_stall", {31'b0, fp_stall_o}, 32'd0);
    check("rst_rsp_valid", {31'b0, csr_rsp_valid_o}, 32'd0);
    tick();
    rst_i = 1'b0;

    // Flags without a preceding issue are ignored
    set_flags(5'b11111);
    tick();
    tick();
    @(negedge clk_i);
    check("flags_only", {27'b0, fflags_o}, 32'd0);
    set_flags(5'b0);
    tick();
    tick();

    // Accumulation: NX, OF|NX, DZ
    fp_valid_i = 1'b1;
    tick();
    set_flags(5'b00001);
    tick();
    set_flags(5'b00101);
    @(negedge clk_i);
    check("acc1", {27'b0, fflags_o}, 32'h01);
    $display("acc fflags=0x%0h", fflags_o);
    tick();
    fp_valid_i = 1'b0;
    set_flags(5'b01000);
    @(negedge clk_i);
    check("acc2", {27'b0, fflags_o}, 32'h05);
    $display("acc fflags=0x%0h", fflags_o);
    tick();
    set_flags(5'b0);
    @(negedge clk_i);
    check("acc3", {27'b0, fflags_o}, 32'h0D);
    $display("acc fflags=0x%0h", fflags_o);
    tick();

    // Read-modify-write through the three views
    csr_txn(2'b01, 12'h003, 32'hE3, 32'h0D, 1'b0, 0);
    check("fcsr_fflags", {27'b0, fflags_o}, 32'h03);
    check("fcsr_frm", {29'b0, frm_o}, 32'd7);
    csr_txn(2'b10, 12'h001, 32'h04, 32'h03, 1'b0, 0);
    check("rs_fflags", {27'b0, fflags_o}, 32'h07);
    csr_txn(2'b11, 12'h003, 32'hE0, 32'hE7, 1'b0, 0);
    check("rc_frm", {29'b0, frm_o}, 32'd0);
    check("rc_fflags", {27'b0, fflags_o}, 32'h07);
    csr_txn(2'b01, 12'h002, 32'h1F, 32'h00, 1'b0, 0);
    check("rw_frm_trunc", {29'b0, frm_o}, 32'd7);

    // Dynamic rounding mode
    csr_txn(2'b01, 12'h002, 32'h3, 32'h7, 1'b0, 0);
    rm_case(3'd7, 3'd3, 1'b0);
    rm_case(3'd2, 3'd2, 1'b0);
    csr_txn(2'b00, 12'h002, 32'h0, 32'h3, 1'b0, 0);
    csr_txn(2'b01, 12'h002, 32'h5, 32'h3, 1'b0, 0);
    rm_case(3'd7, 3'd5, 1'b1);
    rm_case(3'd6, 3'd6, 1'b1);
    rm_case(3'd4, 3'd4, 1'b0);
    instr_rm_i = 3'd0;

    // Unsupported address, response held for four cycles
    csr_txn(2'b00, 12'h004, 32'h0, 32'h0, 1'b1, 4);
    csr_txn(2'b01, 12'h004, 32'hFF, 32'h0, 1'b1, 0);
    check("bad_frm", {29'b0, frm_o}, 32'd5);
    check("bad_fflags", {27'b0, fflags_o}, 32'h07);
    csr_txn(2'b01, 12'h001, 32'h0, 32'h07, 1'b0, 0);

    // Drain: op with NV in flight when the read is accepted
    fp_valid_i      = 1'b1;
    csr_req_valid_i = 1'b1;
    csr_op_i        = 2'b00;
    csr_addr_i      = 12'h001;
    csr_wdata_i     = 32'h0;
    @(negedge clk_i);
    check("drain_ready", {31'b0, csr_req_ready_o}, 32'd1);
    check("drain_stall0", {31'b0, fp_stall_o}, 32'd0);
    tick();
    fp_valid_i      = 1'b0;
    csr_req_valid_i = 1'b0;
    set_flags(5'b10000);
    @(negedge clk_i);
    check("drain_stall1", {31'b0, fp_stall_o}, 32'd1);
    check("drain_rsp1", {31'b0, csr_rsp_valid_o}, 32'd0);
    tick();
    set_flags(5'b0);
    @(negedge clk_i);
    check("drain_stall2", {31'b0, fp_stall_o}, 32'd1);
    check("drain_rsp2", {31'b0, csr_rsp_valid_o}, 32'd0);
    tick();
    @(negedge clk_i);
    check("drain_stall3", {31'b0, fp_stall_o}, 32'd1);
    check("drain_rsp3", {31'b0, csr_rsp_valid_o}, 32'd1);
    check("drain_rdata", csr_rdata_o, 32'h10);
    csr_rsp_ready_i = 1'b1;
    tick();
    csr_rsp_ready_i = 1'b0;
    @(negedge clk_i);
    check("drain_stall_end", {31'b0, fp_stall_o}, 32'd0);
    check("drain_fflags", {27'b0, fflags_o}, 32'h10);
    $display("drain read fflags -> rdata=0x%0h stall=%0d", csr_rdata_o, fp_stall_o);
    tick();

    // Reset while a response is pending
    csr_req_valid_i = 1'b1;
    csr_op_i        = 2'b00;
    csr_addr_i      = 12'h002;
    tick();
    csr_req_valid_i = 1'b0;
    tick();
    @(negedge clk_i);
    check("pre_rst_rsp", {31'b0, csr_rsp_valid_o}, 32'd1);
    tick();
    rst_i = 1'b1;
    #1;
    check("mid_rst_rsp", {31'b0, csr_rsp_valid_o}, 32'd0);
    check("mid_rst_ready", {31'b0, csr_req_ready_o}, 32'd0);
    check("mid_rst_rdata", csr_rdata_o, 32'd0);
    check("mid_rst_fflags", {27'b0, fflags_o}, 32'd0);
    check("mid_rst_frm", {29'b0, frm_o}, 32'd0);
    check("mid_rst_stall", {31'b0, fp_stall_o}, 32'd0);
    $display("reset mid-RESP -> rsp_valid=%0d ready=%0d", csr_rsp_valid_o, csr_req_ready_o);
    tick();
    @(negedge clk_i);
    check("rst_hold_ready", {31'b0, csr_req_ready_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_ready", {31'b0, csr_req_ready_o}, 32'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_csr_flags.md
# fp_csr_flags

Floating-point control/status stage sitting directly downstream of the FPU exception-flag stage. Delays an issue-valid strobe to align with the registered exception flags, accumulates them sticky into `fflags`, holds the `frm` rounding-mode register, and resolves the dynamic rounding mode for issue. Serves CSR read/modify/write requests to `fflags`, `frm` and `fcsr` through a small FSM that drains in-flight flags before each access.

## Interface
- `PIPE_DEPTH`, 1, cycles from `fp_valid_i` to the exception flags being valid (exception stage registers once).
- `clk_i  in  1  clock, all state on posedge`
- `rst_i  in  1  reset; asynchronous, active-high`
- `fp_valid_i  in  1  FP op issued this cycle (same cycle its opcode reaches the exception stage)`
- `fp_stall_o  out  1  issue must hold fp_valid_i low while high`
- `invalid_i, div_zero_i, overflow_i, underflow_i, inexact_i  in  1 each  exception-stage flags`
- `instr_rm_i  in  3  rm field of issuing instruction`
- `eff_rm_o  out  3  resolved rounding mode`
- `rm_illegal_o  out  1  eff_rm_o is reserved (5, 6, 7)`
- `csr_req_valid_i  in  1` / `csr_req_ready_o  out  1  request handshake`
- `csr_op_i  in  2  00 read, 01 RW, 10 RS (set), 11 RC (clear)`
- `csr_addr_i  in  12  0x001 fflags, 0x002 frm, 0x003 fcsr`
- `csr_wdata_i  in  32  write/mask operand`
- `csr_rsp_valid_o  out  1` / `csr_rsp_ready_i  in  1  response handshake`
- `csr_rdata_o  out  32  pre-access CSR value`
- `csr_err_o  out  1  unsupported address, qualified by csr_rsp_valid_o`
- `fflags_o  out  5  {NV,DZ,OF,UF,NX}, bit 4 = NV`
- `frm_o  out  3  rounding-mode register`

## Operation
- Flag pipe: PIPE_DEPTH-bit shift register of `fp_valid_i`; its output `flag_vld` qualifies the five flag inputs. Flags with `flag_vld` low are ignored.
- Accumulate: each cycle `flag_vld`=1, `fflags |= {invalid,div_zero,overflow,underflow,inexact}`. Bits never clear except by CSR write or reset.
- Rounding: `eff_rm_o = (instr_rm_i==3'b111) ? frm : instr_rm_i`; `rm_illegal_o = eff_rm_o >= 5`. Both combinational.
- Views: fflags = {27'b0, fflags}; frm = {29'b0, frm}; fcsr = {24'b0, frm, fflags}. Writes truncate to field width.
- Write value: RW `wdata`; RS `old | wdata`; RC `old & ~wdata`; op 00 no write. fcsr write updates both fields.
- FSM states IDLE, DRAIN, ACCESS, RESP:
  - IDLE: `csr_req_ready_o`=1. On accept, latch op/addr/wdata; go DRAIN if flag pipe non-empty or `fp_valid_i` high this cycle, else ACCESS.
  - DRAIN: wait until pipe empty (its final `flag_vld` accumulates), then ACCESS.
  - ACCESS: capture old value into `csr_rdata_o`, apply write, set `csr_err_o` on bad address; go RESP.
  - RESP: `csr_rsp_valid_o`=1; hold rdata/err stable until `csr_rsp_ready_i`, then IDLE.
- Bad address: rdata 0, err 1, no state change.
- `fp_stall_o = (state != IDLE)`. `fp_valid_i` while stalled is a protocol violation (bench assertion) but is still piped and accumulated.

## Timing
- Reset (async assert, sync-released by system): fflags 0, frm 0, pipe 0, state IDLE, `csr_rsp_valid_o` 0, `csr_rdata_o` 0, `csr_err_o` 0, `fp_stall_o` 0. `csr_req_ready_o` forced 0 while `rst_i` high.
- Flags: `fp_valid_i` in cycle N, flags sampled in cycle N+PIPE_DEPTH, visible on `fflags_o` in N+PIPE_DEPTH+1.
- CSR, pipe empty: accept at edge E; ACCESS cycle E+1; `csr_rsp_valid_o` high from E+2. Written value visible on `fflags_o`/`frm_o` from E+2.
- With drain: +1 cycle per remaining pipe stage.
- Back-to-back: new request accepted no earlier than the cycle after the RESP handshake.
- Reset mid-operation: any state returns to IDLE immediately; latched request and pending flags discarded.

## Test plan
- Reset: assert `rst_i` mid-RESP -> all outputs at reset values same cycle, `csr_rsp_valid_o` 0, ready 0 until release.
- Accumulate: three ops with flags NX, OF|NX, DZ -> `fflags_o` 5'b00001, 5'b00101, 5'b01101 on successive cycles, each PIPE_DEPTH+1 after issue.
- Flags-only cycle: flags high with no prior `fp_valid_i` -> `fflags_o` unchanged 0.
- RMW: fcsr=0xE3, RS fflags wdata 0x04 -> rdata 0x03, fflags 0x07; RC fcsr wdata 0xE0 -> rdata 0xE7, frm 0, fflags 0x07; RW frm 0x1F -> frm 7.
- Drain: `fp_valid_i` with invalid_i, CSR read fflags accepted same cycle -> DRAIN entered, rdata bit4=1, `fp_stall_o` high from the cycle after accept until the RESP handshake.
- Rounding/errors: frm=3, instr_rm 7 -> eff_rm 3, illegal 0; frm=5 -> illegal 1; read addr 0x004 -> err 1, rdata 0, state unchanged; hold `csr_rsp_ready_i` low 4 cycles -> rdata stable.
